// File: rtl/multistep_universal_shift_register.sv
// multistep_universal_shift_register: universal shift/rotate register running one step per clock,
// with a start/busy/done handshake, shift counts and a shifted-out bit.
module multistep_universal_shift_register #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amount,
    input  logic             serial_in_left,
    input  logic             serial_in_right,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [WIDTH-1:0] q,
    output logic             shift_out,
    output logic             busy,
    output logic             done
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [2:0] OP_HOLD  = 3'd0;
    localparam logic [2:0] OP_SHR   = 3'd1;
    localparam logic [2:0] OP_SHL   = 3'd2;
    localparam logic [2:0] OP_LOAD  = 3'd3;
    localparam logic [2:0] OP_ROR   = 3'd4;
    localparam logic [2:0] OP_ROL   = 3'd5;
    localparam logic [2:0] OP_ASR   = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;
    state_t           state_q, state_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             so_q, so_d, done_q, done_d;
    logic [2:0]       cur_op;
    logic [WIDTH-1:0] step_q;
    logic             step_out, is_shift;
    // In RUN the latched op drives the step; in IDLE the incoming op does.
    always_comb begin
        cur_op   = (state_q == RUN) ? op_q : op;
        step_q   = q_q;
        step_out = so_q;
        is_shift = cur_op inside {OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_ASR};
        case (cur_op)
            OP_SHR: begin step_q = {serial_in_left, q_q[WIDTH-1:1]};  step_out = q_q[0];       end
            OP_SHL: begin step_q = {q_q[WIDTH-2:0], serial_in_right}; step_out = q_q[WIDTH-1]; end
            OP_ROR: begin step_q = {q_q[0], q_q[WIDTH-1:1]};          step_out = q_q[0];       end
            OP_ROL: begin step_q = {q_q[WIDTH-2:0], q_q[WIDTH-1]};    step_out = q_q[WIDTH-1]; end
            OP_ASR: begin step_q = {q_q[WIDTH-1], q_q[WIDTH-1:1]};    step_out = q_q[0];       end
            default: ;
        endcase
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        q_d     = q_q;
        so_d    = so_q;
        done_d  = 1'b0;
        if (state_q == RUN) begin
            q_d   = step_q;
            so_d  = step_out;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == AMT_W'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else if (start) begin
            op_d = op;
            if (op == OP_LOAD) q_d = parallel_in;
            if (op == OP_CLEAR) begin
                q_d  = '0;
                so_d = 1'b0;
            end
            if (is_shift && amount != '0) begin
                q_d  = step_q;
                so_d = step_out;
            end
            if (is_shift && amount > AMT_W'(1)) begin
                cnt_d   = amount - 1'b1;
                state_d = RUN;
            end else begin
                done_d = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_HOLD;
            q_q     <= '0;
            so_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            q_q     <= q_d;
            so_q    <= so_d;
            done_q  <= done_d;
        end
    end
    assign q         = q_q;
    assign shift_out = so_q;
    assign busy      = (state_q == RUN);
    assign done      = done_q;
endmodule

// File: tb/tb_multistep_universal_shift_register.sv
// tb_multistep_universal_shift_register: directed table, handshake corner cases and
// randomized commands checked against an arithmetic step model.
module tb_multistep_universal_shift_register;
    logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [2:0] op = '0;
    logic [3:0] amount = '0;
    logic       sil = 1'b0, sir = 1'b0;
    logic [7:0] parallel_in = '0, q;
    logic       shift_out, busy, done;
    int         pass_cnt = 0, total = 0;
    int         m_q = 0, m_so = 0;

    multistep_universal_shift_register #(.WIDTH(8), .AMT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .amount(amount),
        .serial_in_left(sil), .serial_in_right(sir), .parallel_in(parallel_in),
        .q(q), .shift_out(shift_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // One register step on integers, straight from the op table.
    task automatic model_step(input int o, input int l, input int r);
        case (o)
            1: begin m_so = m_q % 2;   m_q = m_q / 2 + l * 128; end
            2: begin m_so = m_q / 128; m_q = (m_q * 2) % 256 + r; end
            4: begin m_so = m_q % 2;   m_q = m_q / 2 + m_so * 128; end
            5: begin m_so = m_q / 128; m_q = (m_q * 2) % 256 + m_so; end
            6: begin m_so = m_q % 2;   m_q = m_q / 2 + ((m_q >= 128) ? 128 : 0); end
            default: ;
        endcase
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the done cycle.
    task automatic cmd(input int o, input int amt, input int pin, input int l, input int r,
                       input bit vary, input bit hold_start);
        bit sh = (o == 1 || o == 2 || o == 4 || o == 5 || o == 6);
        int k = sh ? amt : 0;
        int edges = (k > 1) ? k : 1;
        start = 1'b1; op = 3'(o); amount = 4'(amt); parallel_in = 8'(pin);
        for (int e = 0; e < edges; e++) begin
            sil = vary ? 1'($urandom) : 1'(l);
            sir = vary ? 1'($urandom) : 1'(r);
            if (e == 0 && o == 3) m_q = pin;
            if (e == 0 && o == 7) begin m_q = 0; m_so = 0; end
            if (sh && e < k) model_step(o, int'(sil), int'(sir));
            @(negedge clk);
            if (!hold_start) start = 1'b0;
            op = 3'($urandom); amount = 4'($urandom); parallel_in = 8'($urandom);
            chk("busy", int'(busy), (e < edges - 1) ? 1 : 0);
            chk("done", int'(done), (e == edges - 1) ? 1 : 0);
        end
        chk("q", int'(q), m_q);
        chk("shift_out", int'(shift_out), m_so);
    endtask

    typedef struct {
        int pre; int o; int amt; int pin; int l; int r; int eq; int eso;
    } vec_t;
    vec_t tbl[12];

    initial begin
        tbl[0]  = '{8'h00, 3, 0,  8'hB5, 0, 0, 8'hB5, 0};
        tbl[1]  = '{8'hB5, 1, 3,  0,     1, 0, 8'hF6, 1};
        tbl[2]  = '{8'hB5, 5, 4,  0,     0, 0, 8'h5B, 1};
        tbl[3]  = '{8'h96, 6, 2,  0,     0, 0, 8'hE5, 1};
        tbl[4]  = '{8'h80, 2, 1,  0,     0, 1, 8'h01, 1};
        tbl[5]  = '{8'hB5, 1, 0,  0,     1, 1, 8'hB5, 0};
        tbl[6]  = '{8'hB5, 7, 0,  0,     0, 0, 8'h00, 0};
        tbl[7]  = '{8'h01, 4, 7,  0,     0, 0, 8'h02, 0};
        tbl[8]  = '{8'hA5, 1, 10, 0,     0, 1, 8'h00, 0};
        tbl[9]  = '{8'h3C, 2, 15, 0,     0, 1, 8'hFF, 1};
        tbl[10] = '{8'h5A, 0, 0,  0,     0, 0, 8'h5A, 0};
        tbl[11] = '{8'h81, 4, 1,  0,     0, 0, 8'hC0, 1};

        #2;
        chk("reset_q", int'(q), 0);
        chk("reset_so", int'(shift_out), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            cmd(7, 0, 0, 0, 0, 0, 0);
            cmd(3, 0, tbl[i].pre, 0, 0, 0, 0);
            cmd(tbl[i].o, tbl[i].amt, tbl[i].pin, tbl[i].l, tbl[i].r, 0, 0);
            chk($sformatf("tbl%0d_q", i), int'(q), tbl[i].eq);
            chk($sformatf("tbl%0d_so", i), int'(shift_out), tbl[i].eso);
        end

        // start held high through ROL 4, then accepted again in the done cycle
        cmd(3, 0, 8'hB5, 0, 0, 0, 0);
        cmd(5, 4, 0, 0, 0, 0, 1);
        chk("hold_rol_q", int'(q), 8'h5B);
        cmd(3, 0, 8'h11, 0, 0, 0, 0);
        chk("b2b_load_q", int'(q), 8'h11);
        @(negedge clk);
        chk("done_single", int'(done), 0);

        // asynchronous reset in the middle of ROR 7
        cmd(3, 0, 8'h01, 0, 0, 0, 0);
        start = 1'b1; op = 3'd4; amount = 4'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_busy", int'(busy), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_q", int'(q), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_done", int'(done), 0);
        chk("async_so", int'(shift_out), 0);
        @(negedge clk);
        reset = 1'b0;
        m_q = 0; m_so = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_reset_done", int'(done), 0);
        end

        for (int i = 0; i < 60; i++)
            cmd(int'($urandom_range(7, 0)), int'($urandom_range(15, 0)), int'($urandom_range(255, 0)),
                0, 0, 1, bit'($urandom_range(1, 0)));
        start = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
